// File: rtl/vanish_board_engine.sv
// Vanishing-mark N x N tic-tac-toe engine: board, per-player mark-history FIFOs,
// turn timer and win detection. Each player keeps at most DEPTH live marks.
module vanish_board_engine #(
  parameter int N          = 3,
  parameter int DEPTH      = 3,
  parameter int TURN_TICKS = 80,
  localparam int PW = $clog2(N*N),
  localparam int TW = $clog2(TURN_TICKS+1),
  localparam int CW = $clog2(DEPTH+1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic              new_game,
  input  logic              move_valid,
  input  logic [PW-1:0]     move_pos,
  output logic              move_ready,
  output logic              move_accept,
  output logic              move_reject,
  output logic              vanish_valid,
  output logic [PW-1:0]     vanish_pos,
  output logic              timeout,
  output logic [2*N*N-1:0]  board,
  output logic              turn,
  output logic [TW-1:0]     time_left,
  output logic [1:0]        game_state,
  output logic [CW-1:0]     live_o,
  output logic [CW-1:0]     live_x
);
  localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {RUN = 1'b0, OVER = 1'b1} state_e;

  state_e             state_q;
  logic [2*N*N-1:0]   board_q;
  logic               turn_q;
  logic [TW-1:0]      time_left_q;
  logic [1:0]         game_state_q;
  logic [CW-1:0]      live_q [2];
  logic [PW-1:0]      fifo_q [2][DEPTH];
  logic [PTRW-1:0]    head_q [2];
  logic [PTRW-1:0]    tail_q [2];
  logic               move_accept_q, move_reject_q, vanish_valid_q, timeout_q;
  logic [PW-1:0]      vanish_pos_q;

  logic [1:0]         code_s;
  logic [1:0]         cur_cell_s;
  logic               pos_ok_s, accept_s, full_s, win_s;
  logic [PW-1:0]      pop_pos_s;
  logic [2*N*N-1:0]   board_acc_s;

  function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
    return (p == PTRW'(DEPTH-1)) ? '0 : p + PTRW'(1);
  endfunction

  // True when code c fills any row, column or either main diagonal of b.
  function automatic logic has_line(input logic [2*N*N-1:0] b, input logic [1:0] c);
    logic win, row, col, dia, anti;
    win  = 1'b0;
    dia  = 1'b1;
    anti = 1'b1;
    for (int r = 0; r < N; r++) begin
      row = 1'b1;
      col = 1'b1;
      for (int k = 0; k < N; k++) begin
        row = row & (b[2*(r*N+k) +: 2] == c);
        col = col & (b[2*(k*N+r) +: 2] == c);
      end
      win  = win | row | col;
      dia  = dia  & (b[2*(r*N+r) +: 2] == c);
      anti = anti & (b[2*(r*N+N-1-r) +: 2] == c);
    end
    return win | dia | anti;
  endfunction

  // Move legality and the candidate board after write-and-vanish.
  always_comb begin
    code_s     = turn_q ? 2'b10 : 2'b01;
    pos_ok_s   = (int'(move_pos) < N*N);
    cur_cell_s = 2'b00;
    for (int i = 0; i < N*N; i++) begin
      if (move_pos == PW'(i)) cur_cell_s = board_q[2*i +: 2];
      else                    cur_cell_s = cur_cell_s;
    end
    accept_s    = (state_q == RUN) && move_valid && pos_ok_s && (cur_cell_s == 2'b00);
    full_s      = (live_q[turn_q] == CW'(DEPTH));
    pop_pos_s   = fifo_q[turn_q][head_q[turn_q]];
    board_acc_s = board_q;
    for (int i = 0; i < N*N; i++) begin
      if (move_pos == PW'(i))               board_acc_s[2*i +: 2] = code_s;
      else if (full_s && pop_pos_s == PW'(i)) board_acc_s[2*i +: 2] = 2'b00;
      else                                  board_acc_s[2*i +: 2] = board_acc_s[2*i +: 2];
    end
    win_s = has_line(board_acc_s, code_s);
  end

  // Game state, board, FIFOs, timer and one-cycle status pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= RUN;
      board_q        <= '0;
      turn_q         <= 1'b0;
      time_left_q    <= TW'(TURN_TICKS);
      game_state_q   <= 2'b00;
      move_accept_q  <= 1'b0;
      move_reject_q  <= 1'b0;
      vanish_valid_q <= 1'b0;
      vanish_pos_q   <= '0;
      timeout_q      <= 1'b0;
      for (int p = 0; p < 2; p++) begin
        live_q[p] <= '0;
        head_q[p] <= '0;
        tail_q[p] <= '0;
        for (int d = 0; d < DEPTH; d++) fifo_q[p][d] <= '0;
      end
    end else begin
      move_accept_q  <= 1'b0;
      move_reject_q  <= 1'b0;
      vanish_valid_q <= 1'b0;
      timeout_q      <= 1'b0;
      if (new_game) begin
        state_q      <= RUN;
        board_q      <= '0;
        turn_q       <= 1'b0;
        time_left_q  <= TW'(TURN_TICKS);
        game_state_q <= 2'b00;
        vanish_pos_q <= '0;
        for (int p = 0; p < 2; p++) begin
          live_q[p] <= '0;
          head_q[p] <= '0;
          tail_q[p] <= '0;
        end
      end else if (accept_s) begin
        // An accepted move reloads the timer, so a coincident tick is dropped.
        move_accept_q          <= 1'b1;
        board_q                <= board_acc_s;
        fifo_q[turn_q][tail_q[turn_q]] <= move_pos;
        tail_q[turn_q]         <= ptr_inc(tail_q[turn_q]);
        if (full_s) begin
          head_q[turn_q] <= ptr_inc(head_q[turn_q]);
          vanish_valid_q <= 1'b1;
          vanish_pos_q   <= pop_pos_s;
        end else begin
          live_q[turn_q] <= live_q[turn_q] + CW'(1);
        end
        turn_q      <= ~turn_q;
        time_left_q <= TW'(TURN_TICKS);
        if (win_s) begin
          state_q      <= OVER;
          game_state_q <= code_s;
        end else begin
          state_q <= RUN;
        end
      end else begin
        move_reject_q <= move_valid;
        if (state_q == RUN && tick) begin
          if (time_left_q == TW'(1)) begin
            time_left_q <= TW'(TURN_TICKS);
            turn_q      <= ~turn_q;
            timeout_q   <= 1'b1;
          end else begin
            time_left_q <= time_left_q - TW'(1);
          end
        end else begin
          time_left_q <= time_left_q;
        end
      end
    end
  end

  assign move_ready   = (state_q == RUN);
  assign move_accept  = move_accept_q;
  assign move_reject  = move_reject_q;
  assign vanish_valid = vanish_valid_q;
  assign vanish_pos   = vanish_pos_q;
  assign timeout      = timeout_q;
  assign board        = board_q;
  assign turn         = turn_q;
  assign time_left    = time_left_q;
  assign game_state   = game_state_q;
  assign live_o       = live_q[0];
  assign live_x       = live_q[1];
endmodule
